// File: rtl/serial_frame_sync_if.sv
// Bit-stream input and framed byte output bundle for serial_frame_sync.
// The master side drives the serial bits; the slave side is the synchronizer.
interface serial_frame_sync_if;
  logic        i_bit;
  logic        i_bit_valid;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        o_sof;
  logic        o_eof;
  logic        o_locked;
  logic        o_frame_err;
  logic [15:0] o_frame_cnt;

  modport master (
    output i_bit,
    output i_bit_valid,
    input  o_byte,
    input  o_byte_valid,
    input  o_sof,
    input  o_eof,
    input  o_locked,
    input  o_frame_err,
    input  o_frame_cnt
  );

  modport slave (
    input  i_bit,
    input  i_bit_valid,
    output o_byte,
    output o_byte_valid,
    output o_sof,
    output o_eof,
    output o_locked,
    output o_frame_err,
    output o_frame_cnt
  );
endinterface

// File: rtl/serial_frame_sync.sv
// Hunts a serial bit stream for a fixed sync word, then deserializes a fixed-length
// payload MSB-first into bytes with sof/eof markers; long input gaps abort the frame.
module serial_frame_sync #(
  parameter logic [31:0] SYNC_WORD   = 32'h1ACFFC1D,
  parameter int unsigned SYNC_LEN    = 32,
  parameter int unsigned FRAME_BYTES = 64,
  parameter int unsigned GAP_TIMEOUT = 32
) (
  input logic                clk20m,
  input logic                rst,
  serial_frame_sync_if.slave bus
);

  localparam logic [SYNC_LEN-1:0] SYNC_PAT  = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [15:0]         LAST_BYTE = 16'(FRAME_BYTES - 1);
  localparam logic [7:0]          GAP_LAST  = 8'(GAP_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_HUNT    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t              state_r,     state_s;
  logic [SYNC_LEN-1:0] sync_sr_r,   sync_sr_s;
  logic [SYNC_LEN-1:0] sync_shift_s;
  logic [7:0]          acc_r,       acc_s;
  logic [7:0]          acc_shift_s;
  logic [2:0]          bit_cnt_r,   bit_cnt_s;
  logic [15:0]         byte_cnt_r,  byte_cnt_s;
  logic [7:0]          gap_cnt_r,   gap_cnt_s;
  logic [7:0]          byte_r,      byte_s;
  logic                byte_vld_r,  byte_vld_s;
  logic                sof_r,       sof_s;
  logic                eof_r,       eof_s;
  logic                locked_r,    locked_s;
  logic                frame_err_r, frame_err_s;
  logic [15:0]         frame_cnt_r, frame_cnt_s;

  // Next-state and next-output logic for the hunt/payload machine
  always_comb begin
    state_s      = state_r;
    sync_sr_s    = sync_sr_r;
    acc_s        = acc_r;
    bit_cnt_s    = bit_cnt_r;
    byte_cnt_s   = byte_cnt_r;
    gap_cnt_s    = gap_cnt_r;
    byte_s       = byte_r;
    byte_vld_s   = 1'b0;
    sof_s        = 1'b0;
    eof_s        = 1'b0;
    frame_err_s  = 1'b0;
    frame_cnt_s  = frame_cnt_r;
    sync_shift_s = {sync_sr_r[SYNC_LEN-2:0], bus.i_bit};
    acc_shift_s  = {acc_r[6:0], bus.i_bit};

    case (state_r)
      ST_HUNT: begin
        if (bus.i_bit_valid) begin
          sync_sr_s = sync_shift_s;
          if (sync_shift_s == SYNC_PAT) begin
            state_s    = ST_PAYLOAD;
            acc_s      = 8'd0;
            bit_cnt_s  = 3'd0;
            byte_cnt_s = 16'd0;
            gap_cnt_s  = 8'd0;
          end else begin
            state_s = ST_HUNT;
          end
        end else begin
          sync_sr_s = sync_sr_r;
        end
      end

      ST_PAYLOAD: begin
        if (bus.i_bit_valid) begin
          gap_cnt_s = 8'd0;
          acc_s     = acc_shift_s;
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            byte_s     = acc_shift_s;
            byte_vld_s = 1'b1;
            sof_s      = (byte_cnt_r == 16'd0);
            eof_s      = (byte_cnt_r == LAST_BYTE);
            if (byte_cnt_r == LAST_BYTE) begin
              // Frame complete: the next sync must be built from fresh bits
              frame_cnt_s = frame_cnt_r + 16'd1;
              state_s     = ST_HUNT;
              sync_sr_s   = '0;
              byte_cnt_s  = 16'd0;
            end else begin
              byte_cnt_s = byte_cnt_r + 16'd1;
            end
          end else begin
            byte_cnt_s = byte_cnt_r;
          end
        end else begin
          if (gap_cnt_r == GAP_LAST) begin
            frame_err_s = 1'b1;
            state_s     = ST_HUNT;
            sync_sr_s   = '0;
            acc_s       = 8'd0;
            bit_cnt_s   = 3'd0;
            byte_cnt_s  = 16'd0;
            gap_cnt_s   = 8'd0;
          end else begin
            gap_cnt_s = gap_cnt_r + 8'd1;
          end
        end
      end

      default: begin
        state_s   = ST_HUNT;
        sync_sr_s = '0;
        acc_s     = 8'd0;
        bit_cnt_s = 3'd0;
        gap_cnt_s = 8'd0;
      end
    endcase

    locked_s = (state_s == ST_PAYLOAD);
  end

  // State register and registered outputs; reset wins over every other event
  always_ff @(posedge clk20m) begin
    if (rst) begin
      state_r     <= ST_HUNT;
      sync_sr_r   <= '0;
      acc_r       <= 8'd0;
      bit_cnt_r   <= 3'd0;
      byte_cnt_r  <= 16'd0;
      gap_cnt_r   <= 8'd0;
      byte_r      <= 8'd0;
      byte_vld_r  <= 1'b0;
      sof_r       <= 1'b0;
      eof_r       <= 1'b0;
      locked_r    <= 1'b0;
      frame_err_r <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      state_r     <= state_s;
      sync_sr_r   <= sync_sr_s;
      acc_r       <= acc_s;
      bit_cnt_r   <= bit_cnt_s;
      byte_cnt_r  <= byte_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      byte_r      <= byte_s;
      byte_vld_r  <= byte_vld_s;
      sof_r       <= sof_s;
      eof_r       <= eof_s;
      locked_r    <= locked_s;
      frame_err_r <= frame_err_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  assign bus.o_byte       = byte_r;
  assign bus.o_byte_valid = byte_vld_r;
  assign bus.o_sof        = sof_r;
  assign bus.o_eof        = eof_r;
  assign bus.o_locked     = locked_r;
  assign bus.o_frame_err  = frame_err_r;
  assign bus.o_frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_serial_frame_sync.sv
// Directed + randomized bench for serial_frame_sync, checked every cycle against a
// bit-history reference model, plus explicit byte/count checks per scenario.
module tb_serial_frame_sync;
  localparam logic [31:0] SYNC = 32'h1ACFFC1D;
  localparam int          FB   = 4;
  localparam int          GAP  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  serial_frame_sync_if bus();

  serial_frame_sync #(
    .SYNC_WORD(SYNC), .SYNC_LEN(32), .FRAME_BYTES(FB), .GAP_TIMEOUT(GAP)
  ) dut (
    .clk20m(clk),
    .rst(rst),
    .bus(bus)
  );

  always #25 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_err  = 0;
  logic [7:0] got[$];

  // Reference model: a window of the last 32 received bits while hunting,
  // a running payload bit count while locked.
  bit          m_locked;
  logic [31:0] m_hist;
  int          m_bits, m_acc, m_gap;
  logic [15:0] m_cnt;
  logic [7:0]  e_byte;
  logic        e_bv, e_sof, e_eof, e_err;

  task automatic model_step(input logic r, input logic v, input logic b);
    int idx;
    e_bv = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_err = 1'b0;
    if (r) begin
      m_locked = 1'b0; m_hist = 32'd0; m_bits = 0; m_acc = 0; m_gap = 0;
      m_cnt = 16'd0; e_byte = 8'd0;
    end else if (!m_locked) begin
      if (v) begin
        m_hist = {m_hist[30:0], b};
        if (m_hist == SYNC) begin
          m_locked = 1'b1; m_bits = 0; m_acc = 0; m_gap = 0;
        end
      end
    end else if (v) begin
      m_gap  = 0;
      m_acc  = (m_acc * 2 + int'(b)) % 256;
      m_bits = m_bits + 1;
      if (m_bits % 8 == 0) begin
        idx    = m_bits / 8 - 1;
        e_bv   = 1'b1;
        e_byte = 8'(m_acc);
        e_sof  = (idx == 0);
        e_eof  = (idx == FB - 1);
        if (e_eof) begin
          m_cnt = m_cnt + 16'd1; m_locked = 1'b0; m_hist = 32'd0;
        end
      end
    end else begin
      m_gap = m_gap + 1;
      if (m_gap == GAP) begin
        e_err = 1'b1; m_locked = 1'b0; m_hist = 32'd0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic b);
    rst = r; bus.i_bit_valid = v; bus.i_bit = b;
    model_step(r, v, b);
    @(posedge clk); #1;
    chk("byte_valid", 16'(bus.o_byte_valid), 16'(e_bv));
    chk("sof",        16'(bus.o_sof),        16'(e_sof));
    chk("eof",        16'(bus.o_eof),        16'(e_eof));
    chk("locked",     16'(bus.o_locked),     16'(m_locked));
    chk("frame_err",  16'(bus.o_frame_err),  16'(e_err));
    chk("byte",       16'(bus.o_byte),       16'(e_byte));
    chk("frame_cnt",  bus.o_frame_cnt,       m_cnt);
    if (bus.o_byte_valid === 1'b1) got.push_back(bus.o_byte);
    if (bus.o_frame_err === 1'b1) n_err++;
  endtask

  // Send n MSB-first bits of w, each followed by wt invalid cycles
  task automatic send(input logic [31:0] w, input int n, input int wt);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(1'b0, 1'b1, w[i]);
      for (int k = 0; k < wt; k++) cyc(1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'($urandom));
  endtask

  initial begin
    logic [7:0] pay[4];
    bus.i_bit = 1'b0; bus.i_bit_valid = 1'b0;

    // 1: reset with random inputs
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'($urandom), 1'($urandom));
    chk("t1_locked", 16'(bus.o_locked), 16'd0);
    chk("t1_cnt", bus.o_frame_cnt, 16'd0);

    // 2: clean frame, continuous valid
    got.delete();
    send(SYNC, 32, 0);
    send(32'hA53CFF00, 32, 0);
    idle(3);
    chk("t2_nbytes", 16'(got.size()), 16'd4);
    if (got.size() == 4) begin
      chk("t2_b0", 16'(got[0]), 16'h00A5);
      chk("t2_b1", 16'(got[1]), 16'h003C);
      chk("t2_b2", 16'(got[2]), 16'h00FF);
      chk("t2_b3", 16'(got[3]), 16'h0000);
    end
    chk("t2_cnt", bus.o_frame_cnt, 16'd1);
    chk("t2_locked", 16'(bus.o_locked), 16'd0);

    // 3: sync with one bit flipped
    got.delete();
    send(32'h1ACFFC3D, 32, 0);
    send(32'hA53CFF00, 32, 0);
    idle(2);
    chk("t3_nbytes", 16'(got.size()), 16'd0);
    chk("t3_locked", 16'(bus.o_locked), 16'd0);

    // 4: serializer wait pattern, random bits before sync
    got.delete(); n_err = 0;
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'($urandom), 1'($urandom));
    send(SYNC, 32, 7);
    send(32'hA53CFF00, 32, 7);
    idle(2);
    chk("t4_nbytes", 16'(got.size()), 16'd4);
    if (got.size() == 4) begin
      chk("t4_b0", 16'(got[0]), 16'h00A5);
      chk("t4_b3", 16'(got[3]), 16'h0000);
    end
    chk("t4_err", 16'(n_err), 16'd0);
    chk("t4_cnt", bus.o_frame_cnt, 16'd2);

    // 5a: gap one cycle short of timeout keeps the frame
    got.delete(); n_err = 0;
    send(SYNC, 32, 0);
    send(32'h11223344, 16, 0);
    idle(GAP - 1);
    send(32'h11223344, 16, 0);
    idle(2);
    chk("t5a_err", 16'(n_err), 16'd0);
    chk("t5a_nbytes", 16'(got.size()), 16'd4);
    chk("t5a_cnt", bus.o_frame_cnt, 16'd3);

    // 5b: full timeout after two bytes aborts, next frame is clean
    got.delete(); n_err = 0;
    send(SYNC, 32, 0);
    send(32'h5566, 16, 0);
    idle(GAP);
    idle(2);
    chk("t5b_err", 16'(n_err), 16'd1);
    chk("t5b_cnt", bus.o_frame_cnt, 16'd3);
    chk("t5b_locked", 16'(bus.o_locked), 16'd0);
    got.delete();
    send(SYNC, 32, 0);
    send(32'hDEADBEEF, 32, 0);
    idle(2);
    chk("t5b_nbytes", 16'(got.size()), 16'd4);
    if (got.size() == 4) chk("t5b_b0", 16'(got[0]), 16'h00DE);
    chk("t5b_cnt2", bus.o_frame_cnt, 16'd4);

    // 6: reset mid-byte in payload
    send(SYNC, 32, 0);
    send(32'h5A, 8, 0);
    send(32'h5, 3, 0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t6_locked", 16'(bus.o_locked), 16'd0);
    chk("t6_cnt", bus.o_frame_cnt, 16'd0);
    chk("t6_byte", 16'(bus.o_byte), 16'd0);
    idle(31);
    send(SYNC, 32, 0);
    send(32'h01020304, 32, 0);
    idle(2);
    chk("t6_cnt2", bus.o_frame_cnt, 16'd1);

    // Randomized frames with random gaps, checked by the model every cycle
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'($urandom), 1'($urandom));
      send(SYNC, 32, 0);
      for (int j = 0; j < 4; j++) pay[j] = 8'($urandom);
      for (int j = 0; j < 4; j++)
        for (int i = 7; i >= 0; i--) begin
          cyc(1'b0, 1'b1, pay[j][i]);
          idle(int'($urandom_range(0, 3)));
        end
      idle(2);
    end
    chk("rnd_cnt", bus.o_frame_cnt, 16'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
